imem_responder: RTL and testbench

- Instruction-memory responder serving the fetch stage's PC-driven instruction requests.
- Accepts word-read requests over a valid/ready handshake and returns the instruction after a fixed pipeline latency, in order.
- Buffers responses in a small FIFO so that fetch-side stalls never drop data.
- Provides a write-only load port for testbench or boot-time program loading.

---
 rtl/imem_pkg.sv | 27 ++
 rtl/sync_fifo.sv | 55 +++++
 rtl/imem_responder.sv | 139 +++++++++++++
 tb/tb_imem_responder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction-memory responder.
package imem_pkg;

    localparam int unsigned             IMEM_DWIDTH      = 32;
    localparam int unsigned             IMEM_AWIDTH      = 32;
    localparam logic [IMEM_AWIDTH-1:0]  IMEM_BASEADDR    = 32'h0100_0000;
    localparam int unsigned             IMEM_DEPTH_WORDS = 16384;
    localparam logic [IMEM_DWIDTH-1:0]  IMEM_ERR_DATA    = 32'h0;

    typedef struct packed {
        logic [IMEM_DWIDTH-1:0] data;
        logic [IMEM_AWIDTH-1:0] addr;
        logic                   err;
    } imem_rsp_t;

    // Limit is formed one bit wider so base + 4*depth cannot wrap.
    function automatic logic in_range(
        input logic [IMEM_AWIDTH-1:0] addr,
        input logic [IMEM_AWIDTH-1:0] base        = IMEM_BASEADDR,
        input int unsigned            depth_words = IMEM_DEPTH_WORDS
    );
        logic [IMEM_AWIDTH:0] limit;
        limit = {1'b0, base} + ({1'b0, IMEM_AWIDTH'(depth_words)} << 2);
        return (addr[1:0] == 2'b00) && (addr >= base) && ({1'b0, addr} < limit);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with valid/ready on both sides; pointers wrap modulo DEPTH.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             wr_fire;
    logic             rd_fire;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign wr_ready = (count != CW'(DEPTH));
    assign rd_valid = (count != '0);
    assign wr_fire  = wr_valid & wr_ready;
    assign rd_fire  = rd_valid & rd_ready;
    assign rd_data  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_fire) wr_ptr <= next_ptr(wr_ptr);
            if (rd_fire) rd_ptr <= next_ptr(rd_ptr);
            if (wr_fire && !rd_fire)      count <= count + 1'b1;
            else if (!wr_fire && rd_fire) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: fixed-latency in-order word reads behind a
// credit-checked response FIFO, plus a write-only program-load port.
module imem_responder
    import imem_pkg::*;
#(
    parameter int unsigned            DWIDTH      = 32,
    parameter int unsigned            AWIDTH      = 32,
    parameter logic [AWIDTH-1:0]      BASEADDR    = 32'h0100_0000,
    parameter int unsigned            DEPTH_WORDS = 16384,
    parameter int unsigned            LATENCY     = 2,
    parameter int unsigned            FIFO_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [AWIDTH-1:0] req_addr_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DWIDTH-1:0] rsp_data_o,
    output logic [AWIDTH-1:0] rsp_addr_o,
    output logic              rsp_err_o,
    input  logic              load_en_i,
    input  logic [AWIDTH-1:0] load_addr_i,
    input  logic [DWIDTH-1:0] load_data_i
);

    localparam int unsigned IW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    if (LATENCY < 1 || FIFO_DEPTH < LATENCY + 1 ||
        DWIDTH != IMEM_DWIDTH || AWIDTH != IMEM_AWIDTH) begin : g_param_check
        $error("imem_responder: unsupported parameter combination");
    end

    logic [DWIDTH-1:0] mem [DEPTH_WORDS];
    logic [IW-1:0]     rd_idx;
    logic [IW-1:0]     ld_idx;
    logic              accept;
    logic              consume;
    logic              req_err;
    logic [CW-1:0]     count;
    logic              push_v;
    imem_rsp_t         push_rsp;
    logic              fifo_wr_ready;
    logic              fifo_v;
    imem_rsp_t         fifo_out;

    assign rd_idx  = IW'((req_addr_i - BASEADDR) >> 2);
    assign ld_idx  = IW'((load_addr_i - BASEADDR) >> 2);
    assign req_err = !in_range(req_addr_i, BASEADDR, DEPTH_WORDS);
    assign accept  = req_valid_i & req_ready_o;
    assign consume = rsp_valid_o & rsp_ready_i;

    always_ff @(posedge clk) begin
        if (load_en_i && in_range(load_addr_i, BASEADDR, DEPTH_WORDS)) begin
            mem[ld_idx] <= load_data_i;
        end
    end

    if (LATENCY == 1) begin : g_lat1
        assign push_v = accept;
        always_comb begin
            push_rsp      = '{data: mem[rd_idx], addr: req_addr_i, err: req_err};
            if (req_err) push_rsp.data = IMEM_ERR_DATA;
        end
    end else begin : g_pipe
        localparam int unsigned NST = LATENCY - 1;
        imem_rsp_t        pipe [NST];
        logic [NST-1:0]   pipe_v;

        // Stage 0 reads memory unconditionally (old data on a same-word load);
        // fault masking is applied on the way into the FIFO.
        always_ff @(posedge clk) begin
            pipe[0] <= '{data: mem[rd_idx], addr: req_addr_i, err: req_err};
            for (int unsigned i = 1; i < NST; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                pipe_v <= '0;
            end else begin
                pipe_v[0] <= accept;
                for (int unsigned i = 1; i < NST; i++) begin
                    pipe_v[i] <= pipe_v[i-1];
                end
            end
        end

        assign push_v = pipe_v[NST-1];
        always_comb begin
            push_rsp = pipe[NST-1];
            if (pipe[NST-1].err) push_rsp.data = IMEM_ERR_DATA;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(imem_rsp_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (push_v),
        .wr_ready (fifo_wr_ready),
        .wr_data  (push_rsp),
        .rd_valid (fifo_v),
        .rd_ready (rsp_ready_i),
        .rd_data  (fifo_out)
    );

    a_fifo_room: assert property (@(posedge clk) disable iff (rst) push_v |-> fifo_wr_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (accept && !consume) begin
            count <= count + 1'b1;
        end else if (!accept && consume) begin
            count <= count - 1'b1;
        end
    end

    assign req_ready_o = (count < CW'(FIFO_DEPTH));

    always_comb begin
        rsp_valid_o = fifo_v;
        rsp_data_o  = '0;
        rsp_addr_o  = '0;
        rsp_err_o   = 1'b0;
        if (fifo_v) begin
            rsp_data_o = fifo_out.data;
            rsp_addr_o = fifo_out.addr;
            rsp_err_o  = fifo_out.err;
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: per-cycle scoreboard of handshake
// state and response content, driven by a vector table plus hand sequences.
module tb_imem_responder;

    localparam int unsigned FDEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] req_addr_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_data_o;
    logic [31:0] rsp_addr_o;
    logic        rsp_err_o;
    logic        load_en_i;
    logic [31:0] load_addr_i;
    logic [31:0] load_data_i;

    imem_responder #(
        .DWIDTH      (32),
        .AWIDTH      (32),
        .BASEADDR    (32'h0100_0000),
        .DEPTH_WORDS (16384),
        .LATENCY     (2),
        .FIFO_DEPTH  (FDEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_addr_i  (req_addr_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_data_o  (rsp_data_o),
        .rsp_addr_o  (rsp_addr_o),
        .rsp_err_o   (rsp_err_o),
        .load_en_i   (load_en_i),
        .load_addr_i (load_addr_i),
        .load_data_i (load_data_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [31:0] addr;
        logic        err;
        int unsigned due;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
    } vec_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int unsigned exp_count = 0;
    int          errors = 0;
    int          checks = 0;
    logic        chk_en = 1'b0;
    logic [31:0] drv_data;
    logic        drv_err;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference: response visible once its due cycle is reached, strictly in order.
    always @(negedge clk) begin : mon
        logic        exp_v;
        logic        acc;
        logic        con;
        logic [31:0] ed;
        logic [31:0] ea;
        logic        ee;
        cyc++;
        exp_v = (sb.size() != 0) && (sb[0].due <= cyc);
        ed = exp_v ? sb[0].data : 32'h0;
        ea = exp_v ? sb[0].addr : 32'h0;
        ee = exp_v ? sb[0].err  : 1'b0;
        if (chk_en) begin
            chk("req_ready", 32'(req_ready_o), 32'(exp_count < FDEPTH));
            chk("rsp_valid", 32'(rsp_valid_o), 32'(exp_v));
            chk("rsp_data",  rsp_data_o, ed);
            chk("rsp_addr",  rsp_addr_o, ea);
            chk("rsp_err",   32'(rsp_err_o), 32'(ee));
        end
        if (rst) begin
            sb.delete();
            exp_count = 0;
        end else begin
            con = exp_v && rsp_ready_i;
            acc = req_valid_i && (exp_count < FDEPTH);
            if (con) void'(sb.pop_front());
            if (acc) sb.push_back('{data: drv_data, addr: req_addr_i, err: drv_err, due: cyc + 2});
            if (acc && !con)      exp_count++;
            else if (!acc && con) exp_count--;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [31:0] a, input logic [31:0] d);
        load_en_i   = 1'b1;
        load_addr_i = a;
        load_data_i = d;
        tick();
        load_en_i   = 1'b0;
    endtask

    task automatic set_req(input logic [31:0] a, input logic [31:0] d, input logic e);
        req_valid_i = 1'b1;
        req_addr_i  = a;
        drv_data    = d;
        drv_err     = e;
    endtask

    task automatic drain();
        int unsigned n = 0;
        req_valid_i = 1'b0;
        while (sb.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d responses still pending, required 0", sb.size());
        end
        tick();
    endtask

    vec_t vecs[10];

    initial begin
        rst         = 1'b1;
        req_valid_i = 1'b0;
        req_addr_i  = '0;
        rsp_ready_i = 1'b0;
        load_en_i   = 1'b0;
        load_addr_i = '0;
        load_data_i = '0;
        drv_data    = '0;
        drv_err     = 1'b0;
        repeat (3) tick();
        rst    = 1'b0;
        chk_en = 1'b1;
        tick();

        // Single load then read: response two cycles after accept.
        do_load(32'h0100_0000, 32'hDEAD_BEEF);
        rsp_ready_i = 1'b1;
        set_req(32'h0100_0000, 32'hDEAD_BEEF, 1'b0);
        tick();
        drain();

        // Eight words, then eight back-to-back requests.
        for (int unsigned i = 0; i < 8; i++) do_load(32'h0100_0000 + 4 * i, 32'h100 + i);
        do_load(32'h0100_FFFC, 32'hCAFE_F00D);
        do_load(32'h0101_0000, 32'h5555_5555);
        do_load(32'h0100_0006, 32'h6666_6666);
        for (int unsigned i = 0; i < 8; i++) begin
            set_req(32'h0100_0000 + 4 * i, 32'h100 + i, 1'b0);
            tick();
        end
        drain();

        // Table of faults, boundaries and neighbouring good reads.
        vecs[0] = '{addr: 32'h0100_0000, data: 32'h0000_0100, err: 1'b0};
        vecs[1] = '{addr: 32'h0100_0002, data: 32'h0000_0000, err: 1'b1};
        vecs[2] = '{addr: 32'h0100_0004, data: 32'h0000_0101, err: 1'b0};
        vecs[3] = '{addr: 32'h00FF_FFFC, data: 32'h0000_0000, err: 1'b1};
        vecs[4] = '{addr: 32'h0100_0008, data: 32'h0000_0102, err: 1'b0};
        vecs[5] = '{addr: 32'h0101_0000, data: 32'h0000_0000, err: 1'b1};
        vecs[6] = '{addr: 32'h0100_FFFC, data: 32'hCAFE_F00D, err: 1'b0};
        vecs[7] = '{addr: 32'h0100_0007, data: 32'h0000_0000, err: 1'b1};
        vecs[8] = '{addr: 32'hFFFF_FFFC, data: 32'h0000_0000, err: 1'b1};
        vecs[9] = '{addr: 32'h0100_001C, data: 32'h0000_0107, err: 1'b0};
        for (int unsigned i = 0; i < 10; i++) begin
            set_req(vecs[i].addr, vecs[i].data, vecs[i].err);
            tick();
        end
        drain();

        // Stall: only FDEPTH requests accepted while responses are held off.
        rsp_ready_i = 1'b0;
        for (int unsigned i = 0; i < 7; i++) begin
            set_req(32'h0100_0000 + 4 * i, 32'h100 + i, 1'b0);
            tick();
        end
        req_valid_i = 1'b0;
        do_load(32'h0100_0018, 32'h7777_7777);
        tick();
        rsp_ready_i = 1'b1;
        drain();

        // Read-before-write on the same word in the same cycle.
        do_load(32'h0100_0010, 32'hAAAA_AAAA);
        load_en_i   = 1'b1;
        load_addr_i = 32'h0100_0010;
        load_data_i = 32'h1111_1111;
        set_req(32'h0100_0010, 32'hAAAA_AAAA, 1'b0);
        tick();
        load_en_i = 1'b0;
        set_req(32'h0100_0010, 32'h1111_1111, 1'b0);
        tick();
        drain();

        // Reset with responses both in flight and buffered.
        rsp_ready_i = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            set_req(32'h0100_0000 + 4 * i, 32'h100 + i, 1'b0);
            tick();
        end
        req_valid_i = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rsp_ready_i = 1'b1;
        repeat (6) tick();
        set_req(32'h0100_0004, 32'h0000_0101, 1'b0);
        tick();
        set_req(32'h0100_0010, 32'h1111_1111, 1'b0);
        tick();
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
